// File: rtl/data_check.sv
// GTX loopback receive checker: aligns the RX word stream, locks onto
// the H/F frame pairs, flags bad words and keeps frame/error counts.
module data_check #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 4,
  parameter logic [7:0]  COMMA    = 8'hBC
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CLR_CNT,
  input  logic [31:0] gt0_rxdata,
  input  logic [3:0]  gt0_rxcharisk,
  output logic        LOCKED,
  output logic        ERR,
  output logic        ALIGN,
  output logic [13:0] RX_CNT,
  output logic [31:0] FRAME_CNT,
  output logic [31:0] ERR_CNT
);

  typedef enum logic [1:0] {
    HUNT,
    ALGN,
    CHK_F,
    CHK_H
  } state_t;

  localparam logic [7:0] LOCK_N = 8'(LOCK_CNT);
  localparam logic [7:0] LOSS_N = 8'(LOSS_CNT);

  state_t      state;
  state_t      nxt_state;
  logic [31:0] prev_d;
  logic [3:0]  prev_k;
  logic [7:0]  good_cnt;
  logic [7:0]  bad_cnt;

  logic [31:0] al_d;
  logic [3:0]  al_k;
  logic [13:0] hdr_h;
  logic [13:0] h_p1;
  logic [13:0] h_p2;
  logic        hdr_ok;
  logic        trl_ok;
  logic        raw_hdr;
  logic        raw_hi;

  logic        nxt_align;
  logic        ld_h;
  logic [13:0] ld_val;
  logic        good_frame;
  logic        good_word;
  logic        bad;
  logic        loss;

  // Build the aligned word and classify it (and the raw word for hunting)
  always_comb begin
    al_d = gt0_rxdata;
    al_k = gt0_rxcharisk;
    if (ALIGN) begin
      al_d = {gt0_rxdata[15:0], prev_d[31:16]};
      al_k = {gt0_rxcharisk[1:0], prev_k[3:2]};
    end
    hdr_h  = al_d[31:18];
    h_p1   = RX_CNT + 14'd1;
    h_p2   = RX_CNT + 14'd2;
    hdr_ok = (al_k == 4'b0011) &&
             (al_d[15:0] == {COMMA, COMMA}) &&
             (al_d[17:16] == 2'b00);
    trl_ok = (al_k == 4'b0000) &&
             (al_d[31:16] == 16'h0E0D) &&
             (al_d[1:0] == 2'b00) &&
             (al_d[15:2] == h_p1);
    raw_hdr = (gt0_rxcharisk == 4'b0011) &&
              (gt0_rxdata[15:0] == {COMMA, COMMA}) &&
              (gt0_rxdata[17:16] == 2'b00);
    raw_hi  = (gt0_rxcharisk == 4'b1100) &&
              (gt0_rxdata[31:16] == {COMMA, COMMA});
  end

  // Frame FSM next-state and per-word events
  always_comb begin
    nxt_state  = state;
    nxt_align  = ALIGN;
    ld_h       = 1'b0;
    ld_val     = hdr_h;
    good_frame = 1'b0;
    good_word  = 1'b0;
    bad        = 1'b0;
    loss       = 1'b0;
    unique case (state)
      HUNT: begin
        if (raw_hdr) begin
          nxt_align = 1'b0;
          ld_h      = 1'b1;
          ld_val    = gt0_rxdata[31:18];
          nxt_state = CHK_F;
        end else if (raw_hi) begin
          nxt_align = 1'b1;
          nxt_state = ALGN;
        end
      end
      ALGN: begin
        if (hdr_ok) begin
          ld_h      = 1'b1;
          nxt_state = CHK_F;
        end else begin
          nxt_align = 1'b0;
          nxt_state = HUNT;
        end
      end
      CHK_F: begin
        if (trl_ok) begin
          good_frame = 1'b1;
          good_word  = 1'b1;
          nxt_state  = CHK_H;
        end else if (hdr_ok) begin
          bad  = 1'b1;
          ld_h = 1'b1;
        end else begin
          bad       = 1'b1;
          nxt_state = CHK_H;
        end
      end
      CHK_H: begin
        if (hdr_ok) begin
          ld_h      = 1'b1;
          nxt_state = CHK_F;
          if (hdr_h == h_p2) good_word = 1'b1;
          else               bad       = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
      default: nxt_state = HUNT;
    endcase
    if (bad && (bad_cnt + 8'd1 >= LOSS_N)) begin
      loss      = 1'b1;
      ld_h      = 1'b0;
      nxt_state = HUNT;
    end
  end

  // State, alignment history, header field and lock tracking
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= HUNT;
      prev_d   <= '0;
      prev_k   <= '0;
      ALIGN    <= 1'b0;
      ERR      <= 1'b0;
      LOCKED   <= 1'b0;
      RX_CNT   <= '0;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      state  <= nxt_state;
      prev_d <= gt0_rxdata;
      prev_k <= gt0_rxcharisk;
      ALIGN  <= nxt_align;
      ERR    <= bad;
      if (ld_h) RX_CNT <= ld_val;
      if (loss) begin
        good_cnt <= '0;
        bad_cnt  <= '0;
        LOCKED   <= 1'b0;
      end else if (bad) begin
        good_cnt <= '0;
        bad_cnt  <= bad_cnt + 8'd1;
      end else if (good_word) begin
        bad_cnt <= '0;
        if (good_frame && good_cnt < LOCK_N)
          good_cnt <= good_cnt + 8'd1;
        if (good_frame && good_cnt + 8'd1 >= LOCK_N)
          LOCKED <= 1'b1;
      end
    end
  end

  // Saturating frame/error statistics; a clear beats an increment
  always_ff @(posedge CLK) begin
    if (RST || CLR_CNT) begin
      FRAME_CNT <= '0;
      ERR_CNT   <= '0;
    end else begin
      if (good_frame && FRAME_CNT != 32'hFFFF_FFFF)
        FRAME_CNT <= FRAME_CNT + 32'd1;
      if (bad && ERR_CNT != 32'hFFFF_FFFF)
        ERR_CNT <= ERR_CNT + 32'd1;
    end
  end

endmodule

// File: tb/tb_data_check.sv
// Directed bench for data_check: aligned and shifted streams, wrap,
// corruption, skipped frame, loss/relock, counter clear and reset.
module tb_data_check;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CLR_CNT;
  logic [31:0] gt0_rxdata;
  logic [3:0]  gt0_rxcharisk;
  logic        LOCKED;
  logic        ERR;
  logic        ALIGN;
  logic [13:0] RX_CNT;
  logic [31:0] FRAME_CNT;
  logic [31:0] ERR_CNT;

  int n_cmp = 0;
  int n_bad = 0;
  int n_err = 0;
  int e0;

  logic        shift = 1'b0;
  logic [15:0] hold_d = '0;
  logic [1:0]  hold_k = '0;
  logic [13:0] c;
  logic [31:0] w;

  data_check dut (
    .CLK          (CLK),
    .RST          (RST),
    .CLR_CNT      (CLR_CNT),
    .gt0_rxdata   (gt0_rxdata),
    .gt0_rxcharisk(gt0_rxcharisk),
    .LOCKED       (LOCKED),
    .ERR          (ERR),
    .ALIGN        (ALIGN),
    .RX_CNT       (RX_CNT),
    .FRAME_CNT    (FRAME_CNT),
    .ERR_CNT      (ERR_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hw(input logic [13:0] cv);
    return {cv, 2'b00, 8'hBC, 8'hBC};
  endfunction

  function automatic logic [31:0] fw(input logic [13:0] cv);
    logic [13:0] n;
    n = cv + 14'd1;
    return {8'h0E, 8'h0D, n, 2'b00};
  endfunction

  task automatic step(input logic [31:0] d, input logic [3:0] k);
    if (shift) begin
      gt0_rxdata    = {d[15:0], hold_d};
      gt0_rxcharisk = {k[1:0], hold_k};
    end else begin
      gt0_rxdata    = d;
      gt0_rxcharisk = k;
    end
    hold_d = d[31:16];
    hold_k = k[3:2];
    @(posedge CLK);
    #1;
    if (ERR) n_err++;
  endtask

  task automatic send_h(input logic [13:0] cv);
    step(hw(cv), 4'b0011);
  endtask

  task automatic send_f(input logic [13:0] cv);
    step(fw(cv), 4'b0000);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step(32'h0, 4'h0);
    step(32'h0, 4'h0);
    RST    = 1'b0;
    hold_d = '0;
    hold_k = '0;
  endtask

  initial begin
    RST           = 1'b1;
    CLR_CNT       = 1'b0;
    gt0_rxdata    = '0;
    gt0_rxcharisk = '0;
    do_reset();
    chk("rst_lock", {31'b0, LOCKED}, 32'd0);
    chk("rst_err", {31'b0, ERR}, 32'd0);
    chk("rst_align", {31'b0, ALIGN}, 32'd0);
    chk("rst_rx", {18'b0, RX_CNT}, 32'd0);
    chk("rst_frm", FRAME_CNT, 32'd0);
    chk("rst_ecnt", ERR_CNT, 32'd0);

    // aligned stream from 0
    e0 = n_err;
    c  = 14'd0;
    for (int k = 0; k < 6; k++) begin
      send_h(c);
      chk("t1_rx", {18'b0, RX_CNT}, {18'b0, c});
      send_f(c);
      chk("t1_frm", FRAME_CNT, 32'(k + 1));
      chk("t1_lock", {31'b0, LOCKED}, 32'(k >= 3));
      c = c + 14'd2;
    end
    chk("t1_align", {31'b0, ALIGN}, 32'd0);
    chk("t1_ecnt", ERR_CNT, 32'd0);
    chk("t1_errs", 32'(n_err - e0), 32'd0);

    // stream shifted by two bytes
    do_reset();
    shift = 1'b1;
    e0    = n_err;
    c     = 14'h0100;
    for (int k = 0; k < 6; k++) begin
      send_h(c);
      if (k == 0) chk("t2_align", {31'b0, ALIGN}, 32'd1);
      if (k >= 1) begin
        chk("t2_frm", FRAME_CNT, 32'(k));
        chk("t2_lock", {31'b0, LOCKED}, 32'(k >= 4));
      end
      send_f(c);
      chk("t2_rx", {18'b0, RX_CNT}, {18'b0, c});
      c = c + 14'd2;
    end
    send_h(c);
    chk("t2_frm_end", FRAME_CNT, 32'd6);
    chk("t2_lock_end", {31'b0, LOCKED}, 32'd1);
    chk("t2_align_end", {31'b0, ALIGN}, 32'd1);
    chk("t2_errs", 32'(n_err - e0), 32'd0);

    // counter wrap
    shift = 1'b0;
    do_reset();
    e0 = n_err;
    c  = 14'h3FF8;
    for (int k = 0; k < 20; k++) begin
      send_h(c);
      if (c == 14'h0000) chk("t3_wrap_rx", {18'b0, RX_CNT}, 32'd0);
      send_f(c);
      c = c + 14'd2;
    end
    chk("t3_frm", FRAME_CNT, 32'd20);
    chk("t3_ecnt", ERR_CNT, 32'd0);
    chk("t3_errs", 32'(n_err - e0), 32'd0);
    chk("t3_rx", {18'b0, RX_CNT}, 32'h1E);
    chk("t3_lock", {31'b0, LOCKED}, 32'd1);

    // corrupt byte 3 of one trailer
    send_h(14'h20);
    w = fw(14'h20);
    w[31:24] = 8'h0F;
    step(w, 4'b0000);
    chk("t4_err", {31'b0, ERR}, 32'd1);
    send_h(14'h22);
    chk("t4_err_off", {31'b0, ERR}, 32'd0);
    send_f(14'h22);
    chk("t4_ecnt", ERR_CNT, 32'd1);
    chk("t4_lock", {31'b0, LOCKED}, 32'd1);
    chk("t4_frm", FRAME_CNT, 32'd21);

    // skipped H/F pair
    send_h(14'h24);
    send_f(14'h24);
    send_h(14'h28);
    chk("t5_err", {31'b0, ERR}, 32'd1);
    chk("t5_rx", {18'b0, RX_CNT}, 32'h28);
    send_f(14'h28);
    chk("t5_err_off", {31'b0, ERR}, 32'd0);
    chk("t5_frm_a", FRAME_CNT, 32'd23);
    send_h(14'h2A);
    send_f(14'h2A);
    chk("t5_ecnt", ERR_CNT, 32'd2);
    chk("t5_frm_b", FRAME_CNT, 32'd24);
    chk("t5_lock", {31'b0, LOCKED}, 32'd1);

    // zero words: loss of lock, then relock
    e0 = n_err;
    for (int i = 1; i <= 8; i++) begin
      step(32'h0, 4'h0);
      if (i == 3) chk("t6_lock3", {31'b0, LOCKED}, 32'd1);
      if (i == 4) begin
        chk("t6_lock4", {31'b0, LOCKED}, 32'd0);
        chk("t6_err4", {31'b0, ERR}, 32'd1);
      end
    end
    chk("t6_ecnt", ERR_CNT, 32'd6);
    chk("t6_errs", 32'(n_err - e0), 32'd4);
    c = 14'h40;
    for (int k = 0; k < 5; k++) begin
      send_h(c);
      send_f(c);
      if (k == 2) chk("t6_relock3", {31'b0, LOCKED}, 32'd0);
      if (k == 3) chk("t6_relock4", {31'b0, LOCKED}, 32'd1);
      c = c + 14'd2;
    end
    chk("t6_frm", FRAME_CNT, 32'd29);

    // clear coinciding with a good frame
    send_h(c);
    CLR_CNT = 1'b1;
    send_f(c);
    CLR_CNT = 1'b0;
    chk("clr_frm", FRAME_CNT, 32'd0);
    chk("clr_ecnt", ERR_CNT, 32'd0);
    chk("clr_lock", {31'b0, LOCKED}, 32'd1);
    c = c + 14'd2;
    send_h(c);
    send_f(c);
    chk("clr_frm_after", FRAME_CNT, 32'd1);

    // reset mid-frame
    c = c + 14'd2;
    send_h(c);
    RST = 1'b1;
    send_f(c);
    chk("mid_rst_lock", {31'b0, LOCKED}, 32'd0);
    chk("mid_rst_err", {31'b0, ERR}, 32'd0);
    chk("mid_rst_align", {31'b0, ALIGN}, 32'd0);
    chk("mid_rst_rx", {18'b0, RX_CNT}, 32'd0);
    chk("mid_rst_frm", FRAME_CNT, 32'd0);
    chk("mid_rst_ecnt", ERR_CNT, 32'd0);
    RST = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
